// File: rtl/hh_gate_euler.sv
// rtl/hh_gate_euler.sv - forward-Euler update of one HH gating variable using one shared multiplier
module hh_gate_euler #(
    parameter int W      = 22,
    parameter int FRAC   = 12,
    parameter int DT     = 41,
    parameter int G_INIT = 1297
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] alpha,
    input  logic [W-1:0] beta,
    input  logic         init_load,
    input  logic [W-1:0] init_val,
    output logic [W-1:0] g_out,
    output logic         out_valid,
    output logic         busy
);

    typedef enum logic [2:0] {IDLE, MUL1, MUL2, MUL3, UPD} state_t;

    localparam logic signed [W-1:0] ONE   = W'(1 << FRAC);
    localparam logic signed [W-1:0] DT_C  = W'(DT);
    localparam logic signed [W-1:0] G_RST = W'(G_INIT);
    localparam logic signed [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};

    state_t state_q, state_d;
    logic signed [W-1:0] a_q, a_d, b_q, b_d, g_q, g_d;
    logic signed [W-1:0] t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
    logic                ov_q, ov_d;

    logic signed [W-1:0]   op_a, op_b, mul_res, diff_sat;
    logic signed [2*W-1:0] prod;
    logic signed [W:0]     diff, sum;

    // Gate values live in [0, 1.0]; anything outside is pinned to the nearest bound.
    function automatic logic signed [W-1:0] clamp_g(input logic signed [W:0] x);
        if (x[W])
            return '0;
        else if (x > $signed({1'b0, ONE}))
            return ONE;
        else
            return x[W-1:0];
    endfunction

    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state_q)
            MUL1: begin op_a = a_q;  op_b = ONE - g_q; end
            MUL2: begin op_a = b_q;  op_b = g_q;       end
            MUL3: begin op_a = DT_C; op_b = diff_sat;  end
            default: ;
        endcase
    end

    assign prod    = op_a * op_b;
    assign mul_res = prod[W+FRAC-1:FRAC];

    assign diff     = {t1_q[W-1], t1_q} - {t2_q[W-1], t2_q};
    assign diff_sat = (diff[W] != diff[W-1]) ? (diff[W] ? S_MIN : S_MAX) : diff[W-1:0];
    assign sum      = {g_q[W-1], g_q} + {t3_q[W-1], t3_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        g_d     = g_q;
        t1_d    = t1_q;
        t2_d    = t2_q;
        t3_d    = t3_q;
        ov_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (init_load) begin
                    g_d = clamp_g({init_val[W-1], init_val});
                end else if (in_valid) begin
                    a_d     = alpha;
                    b_d     = beta;
                    state_d = MUL1;
                end
            end
            MUL1: begin t1_d = mul_res; state_d = MUL2; end
            MUL2: begin t2_d = mul_res; state_d = MUL3; end
            MUL3: begin t3_d = mul_res; state_d = UPD;  end
            UPD: begin
                g_d     = clamp_g(sum);
                ov_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            g_q     <= G_RST;
            t1_q    <= '0;
            t2_q    <= '0;
            t3_q    <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            g_q     <= g_d;
            t1_q    <= t1_d;
            t2_q    <= t2_d;
            t3_q    <= t3_d;
            ov_q    <= ov_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !init_load;
    assign busy      = (state_q != IDLE);
    assign g_out     = g_q;
    assign out_valid = ov_q;

endmodule
